usb_hid_ch559_rx_core: RTL and testbench

- Parametrised successor to the fixed 400 kbaud CH559 HID interface: integrated UART receiver plus full CH559 frame parser.
- Routes each HID report to a keyboard, mouse or gamepad channel with configurable widths.
- Commits a report only after a frame validates. Adds inter-byte timeout, length checking and error reporting.
- Sits between the CH559 TXD pin and the host-side HID consumers.

---
 rtl/usb_hid_ch559_rx_core.sv | 233 +++++++++++++++++++++++
 tb/tb_usb_hid_ch559_rx_core.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_hid_ch559_rx_core.sv
// CH559 HID receiver: 8N1 UART plus frame parser routing reports to keyboard, mouse and gamepad channels.
// Optional saturating error counter is built when CH559_ERR_CNT_EN is defined.
module usb_hid_ch559_rx_core #(
    parameter int CLK_HZ       = 80000000,
    parameter int BAUD         = 400000,
    parameter int KB_BYTES     = 8,
    parameter int MS_BYTES     = 4,
    parameter int GP_BYTES     = 8,
    parameter int MAX_LEN      = 64,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rxd,
    output logic [8*KB_BYTES-1:0] kb_data,
    output logic                  kb_rdy,
    output logic [8*MS_BYTES-1:0] ms_data,
    output logic                  ms_rdy,
    output logic [8*GP_BYTES-1:0] gp_data,
    output logic                  gp_rdy,
    output logic                  err_pulse,
    output logic [7:0]            err_cnt
);
    localparam int DIV      = CLK_HZ / BAUD;
    localparam int HALF     = DIV / 2;
    localparam int CW       = $clog2(DIV);
    localparam int TO_LIM   = TIMEOUT_BITS * DIV;
    localparam int GW       = $clog2(TO_LIM + 1);
    localparam int SH_BYTES = (KB_BYTES >= MS_BYTES)
                            ? ((KB_BYTES >= GP_BYTES) ? KB_BYTES : GP_BYTES)
                            : ((MS_BYTES >= GP_BYTES) ? MS_BYTES : GP_BYTES);

    typedef enum logic [2:0] {U_IDLE, U_START, U_DATA, U_STOP, U_WAIT} uart_state_t;
    typedef enum logic [3:0] {
        P_IDLE, P_LEN0, P_LEN1, P_MSG, P_DTYPE, P_DIDX, P_EP,
        P_VID0, P_VID1, P_PID0, P_PID1, P_PAY, P_TERM
    } parse_state_t;
    typedef enum logic [1:0] {CH_NONE, CH_KB, CH_MS, CH_GP} chan_t;

    logic [1:0]  r_sync;
    uart_state_t r_ustate;
    logic [CW-1:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_byte_valid;
    logic        r_frame_err;
    logic        w_rx;

    // NOTE: synchronizer flops reset to the idle-high line level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_sync <= 2'b11;
        else        r_sync <= {r_sync[0], rxd};
    end
    assign w_rx = r_sync[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ustate     <= U_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_ustate)
                U_IDLE: if (!w_rx) begin
                    r_cnt    <= '0;
                    r_ustate <= U_START;
                end
                U_START: if (r_cnt == CW'(HALF - 1)) begin
                    r_cnt <= '0;
                    r_bit <= '0;
                    r_ustate <= w_rx ? U_IDLE : U_DATA;
                end else r_cnt <= r_cnt + CW'(1);
                U_DATA: if (r_cnt == CW'(DIV - 1)) begin
                    r_cnt   <= '0;
                    r_shift <= {w_rx, r_shift[7:1]};
                    r_bit   <= r_bit + 3'd1;
                    if (r_bit == 3'd7) r_ustate <= U_STOP;
                end else r_cnt <= r_cnt + CW'(1);
                U_STOP: if (r_cnt == CW'(DIV - 1)) begin
                    r_cnt <= '0;
                    if (w_rx) begin
                        r_byte_valid <= 1'b1;
                        r_ustate     <= U_IDLE;
                    end else begin
                        r_frame_err <= 1'b1;
                        r_ustate    <= U_WAIT;
                    end
                end else r_cnt <= r_cnt + CW'(1);
                U_WAIT: if (w_rx) r_ustate <= U_IDLE;
                default: r_ustate <= U_IDLE;
            endcase
        end
    end

    parse_state_t         r_pstate;
    chan_t                r_chan;
    logic [7:0]           r_len_lo;
    logic [15:0]          r_len;
    logic [7:0]           r_msg;
    logic [15:0]          r_pay_cnt;
    logic [GW-1:0]        r_gap;
    logic [8*SH_BYTES-1:0] r_shadow;
    logic [15:0]          w_chan_bytes;
    logic                 w_timeout;

    always_comb begin
        w_chan_bytes = '0;
        case (r_chan)
            CH_KB:   w_chan_bytes = 16'(KB_BYTES);
            CH_MS:   w_chan_bytes = 16'(MS_BYTES);
            CH_GP:   w_chan_bytes = 16'(GP_BYTES);
            default: w_chan_bytes = '0;
        endcase
    end

    assign w_timeout = (r_pstate != P_IDLE) && (r_gap == GW'(TO_LIM));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pstate  <= P_IDLE;
            r_chan    <= CH_NONE;
            r_len_lo  <= '0;
            r_len     <= '0;
            r_msg     <= '0;
            r_pay_cnt <= '0;
            r_gap     <= '0;
            r_shadow  <= '0;
            kb_data   <= '0;
            ms_data   <= '0;
            gp_data   <= '0;
            kb_rdy    <= 1'b0;
            ms_rdy    <= 1'b0;
            gp_rdy    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            kb_rdy    <= 1'b0;
            ms_rdy    <= 1'b0;
            gp_rdy    <= 1'b0;
            err_pulse <= 1'b0;
            // Framing error and timeout share one abort path, so a coincidence yields a single pulse.
            if (r_frame_err || w_timeout) begin
                err_pulse <= 1'b1;
                r_pstate  <= P_IDLE;
                r_chan    <= CH_NONE;
                r_gap     <= '0;
                r_shadow  <= '0;
            end else begin
                r_gap <= (r_pstate == P_IDLE || r_byte_valid) ? '0 : r_gap + GW'(1);
                if (r_byte_valid) begin
                    case (r_pstate)
                        P_IDLE:  if (r_shift == 8'hFE) r_pstate <= P_LEN0;
                        P_LEN0: begin
                            r_len_lo <= r_shift;
                            r_pstate <= P_LEN1;
                        end
                        P_LEN1: if ({r_shift, r_len_lo} > 16'(MAX_LEN)) begin
                            err_pulse <= 1'b1;
                            r_pstate  <= P_IDLE;
                        end else begin
                            r_len    <= {r_shift, r_len_lo};
                            r_pstate <= P_MSG;
                        end
                        P_MSG: begin
                            r_msg    <= r_shift;
                            r_pstate <= P_DTYPE;
                        end
                        P_DTYPE: begin
                            r_chan <= CH_NONE;
                            if (r_msg == 8'h04) begin
                                case (r_shift)
                                    8'h06:   r_chan <= CH_KB;
                                    8'h02:   r_chan <= CH_MS;
                                    8'h04:   r_chan <= CH_GP;
                                    default: r_chan <= CH_NONE;
                                endcase
                            end
                            r_pstate <= P_DIDX;
                        end
                        P_DIDX: r_pstate <= P_EP;
                        P_EP:   r_pstate <= P_VID0;
                        P_VID0: r_pstate <= P_VID1;
                        P_VID1: r_pstate <= P_PID0;
                        P_PID0: r_pstate <= P_PID1;
                        P_PID1: begin
                            r_shadow  <= '0;
                            r_pay_cnt <= '0;
                            r_pstate  <= (r_len == 16'd0) ? P_TERM : P_PAY;
                        end
                        P_PAY: begin
                            for (int k = 0; k < SH_BYTES; k++) begin
                                if (r_pay_cnt == 16'(k) && 16'(k) < w_chan_bytes)
                                    r_shadow[8*k +: 8] <= r_shift;
                            end
                            r_pay_cnt <= r_pay_cnt + 16'd1;
                            if (r_pay_cnt == r_len - 16'd1) r_pstate <= P_TERM;
                        end
                        P_TERM: begin
                            if (r_shift == 8'h0A) begin
                                case (r_chan)
                                    CH_KB: begin kb_data <= r_shadow[8*KB_BYTES-1:0]; kb_rdy <= 1'b1; end
                                    CH_MS: begin ms_data <= r_shadow[8*MS_BYTES-1:0]; ms_rdy <= 1'b1; end
                                    CH_GP: begin gp_data <= r_shadow[8*GP_BYTES-1:0]; gp_rdy <= 1'b1; end
                                    default: ;
                                endcase
                            end else begin
                                err_pulse <= 1'b1;
                            end
                            r_chan   <= CH_NONE;
                            r_pstate <= P_IDLE;
                        end
                        default: r_pstate <= P_IDLE;
                    endcase
                end
            end
        end
    end

`ifdef CH559_ERR_CNT_EN
    logic [7:0] r_err_cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                              r_err_cnt <= '0;
        else if (err_pulse && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_usb_hid_ch559_rx_core.sv
// Self-checking bench for usb_hid_ch559_rx_core: serial frames in, committed reports and error pulses compared
// against a frame-level reference model. Runs at DIV=16 to keep the cycle count small.
`timescale 1ns/1ps
module tb_usb_hid_ch559_rx_core;
    localparam int CLK_HZ   = 1600000;
    localparam int BAUD     = 100000;
    localparam int DIV      = CLK_HZ / BAUD;
    localparam int KB_BYTES = 8;
    localparam int MS_BYTES = 4;
    localparam int GP_BYTES = 8;
    localparam int MAX_LEN  = 64;
    localparam int TO_BITS  = 40;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rxd = 1'b1;
    logic [63:0] kb_data;
    logic [31:0] ms_data;
    logic [63:0] gp_data;
    logic        kb_rdy, ms_rdy, gp_rdy, err_pulse;
    logic [7:0]  err_cnt;

    usb_hid_ch559_rx_core #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .KB_BYTES(KB_BYTES), .MS_BYTES(MS_BYTES),
        .GP_BYTES(GP_BYTES), .MAX_LEN(MAX_LEN), .TIMEOUT_BITS(TO_BITS)
    ) dut (
        .clk(clk), .reset(reset), .rxd(rxd),
        .kb_data(kb_data), .kb_rdy(kb_rdy), .ms_data(ms_data), .ms_rdy(ms_rdy),
        .gp_data(gp_data), .gp_rdy(gp_rdy), .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // observed pulse counts and protocol violations (wide pulses, commit together with error)
    int   n_kb = 0, n_ms = 0, n_gp = 0, n_err = 0, n_bad = 0;
    logic p_kb = 1'b0, p_ms = 1'b0, p_gp = 1'b0;

    always @(negedge clk) begin
        if (kb_rdy)    n_kb  <= n_kb + 1;
        if (ms_rdy)    n_ms  <= n_ms + 1;
        if (gp_rdy)    n_gp  <= n_gp + 1;
        if (err_pulse) n_err <= n_err + 1;
        if ((kb_rdy && p_kb) || (ms_rdy && p_ms) || (gp_rdy && p_gp) ||
            (err_pulse && (kb_rdy || ms_rdy || gp_rdy)))
            n_bad <= n_bad + 1;
        p_kb <= kb_rdy;
        p_ms <= ms_rdy;
        p_gp <= gp_rdy;
    end

    // reference model state
    logic [63:0] exp_kb = '0;
    logic [31:0] exp_ms = '0;
    logic [63:0] exp_gp = '0;
    int e_kb = 0, e_ms = 0, e_gp = 0, e_err = 0, e_errcnt = 0;

    function automatic logic [7:0] exp_err_cnt();
`ifdef CH559_ERR_CNT_EN
        return (e_errcnt > 255) ? 8'hFF : 8'(e_errcnt);
`else
        return 8'h00;
`endif
    endfunction

    // Frame-level model: decide commit/error from the whole byte list of one well-formed-or-bad frame.
    task automatic model_frame(input bq_t f);
        int          len;
        int          w;
        logic [63:0] v;
        len = int'({f[2], f[1]});
        if (len > MAX_LEN) begin e_err++; e_errcnt++; return; end
        if (f[11+len] != 8'h0A) begin e_err++; e_errcnt++; return; end
        w = 0;
        if (f[3] == 8'h04) begin
            if (f[4] == 8'h06) w = KB_BYTES;
            if (f[4] == 8'h02) w = MS_BYTES;
            if (f[4] == 8'h04) w = GP_BYTES;
        end
        if (w == 0) return;
        v = '0;
        for (int i = 0; i < len && i < w; i++) v = v | (64'(f[11+i]) << (8*i));
        if (f[4] == 8'h06) begin exp_kb = v; e_kb++; end
        if (f[4] == 8'h02) begin exp_ms = v[31:0]; e_ms++; end
        if (f[4] == 8'h04) begin exp_gp = v; e_gp++; end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int idle_bits);
        rxd = 1'b0;
        repeat (DIV) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(posedge clk);
        end
        rxd = stop;
        repeat (DIV) @(posedge clk);
        rxd = 1'b1;
        repeat (idle_bits * DIV) @(posedge clk);
    endtask

    task automatic send_frame(input bq_t f);
        foreach (f[i]) send_byte(f[i], 1'b1, $urandom_range(0, 1));
    endtask

    task automatic settle();
        repeat (2 * DIV) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({kb_data, ms_data, gp_data, kb_rdy, ms_rdy, gp_rdy, err_pulse, err_cnt} !== '0) begin errors++; $display("FAIL reset_hold outputs got kb=%h ms=%h gp=%h err_cnt=%h expected all 0", kb_data, ms_data, gp_data, err_cnt); end
        reset = 1'b1;
        settle();
        checks++; if ({kb_data, ms_data, gp_data, err_cnt} !== '0 || n_err !== 0) begin errors++; $display("FAIL reset_release outputs got kb=%h ms=%h gp=%h errs=%0d expected all 0", kb_data, ms_data, gp_data, n_err); end
    endtask

    task automatic test_keyboard();
        bq_t f;
        f = '{8'hFE, 8'h08, 8'h00, 8'h04, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h02, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0A};
        send_frame(f);
        model_frame(f);
        settle();
        checks++; if (kb_data !== 64'h0000000000040002) begin errors++; $display("FAIL kb_commit kb_data got %h expected 0000000000040002", kb_data); end
        checks++; if (n_kb !== e_kb || n_ms !== e_ms || n_gp !== e_gp) begin errors++; $display("FAIL kb_pulses got kb/ms/gp %0d/%0d/%0d expected %0d/%0d/%0d", n_kb, n_ms, n_gp, e_kb, e_ms, e_gp); end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL kb_pulse_width got %0d violations expected 0", n_bad); end
    endtask

    task automatic test_mouse_zero_fill();
        bq_t f;
        f = '{8'hFE, 8'h03, 8'h00, 8'h04, 8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h01, 8'h05, 8'hFB, 8'h0A};
        send_frame(f);
        model_frame(f);
        settle();
        checks++; if (ms_data !== 32'h00FB0501 || n_ms !== e_ms) begin errors++; $display("FAIL ms_short ms_data got %h pulses %0d expected 00fb0501 pulses %0d", ms_data, n_ms, e_ms); end
        f = '{8'hFE, 8'h06, 8'h00, 8'h04, 8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h0A};
        send_frame(f);
        model_frame(f);
        settle();
        checks++; if (ms_data !== 32'h04030201 || n_ms !== e_ms) begin errors++; $display("FAIL ms_long ms_data got %h pulses %0d expected 04030201 pulses %0d", ms_data, n_ms, e_ms); end
        checks++; if (kb_data !== exp_kb || n_kb !== e_kb) begin errors++; $display("FAIL ms_kb_untouched kb_data got %h expected %h", kb_data, exp_kb); end
    endtask

    task automatic test_gamepad_excess();
        bq_t f;
        f = '{8'hFE, 8'h09, 8'h00, 8'h04, 8'h04, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
              8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9, 8'h0A};
        send_frame(f);
        model_frame(f);
        settle();
        checks++; if (gp_data !== 64'hA8A7A6A5A4A3A2A1 || n_gp !== e_gp) begin errors++; $display("FAIL gp_excess gp_data got %h pulses %0d expected a8a7a6a5a4a3a2a1 pulses %0d", gp_data, n_gp, e_gp); end
    endtask

    task automatic test_bad_term();
        bq_t f;
        f = '{8'hFE, 8'h08, 8'h00, 8'h04, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h0B};
        send_frame(f);
        model_frame(f);
        settle();
        checks++; if (kb_data !== exp_kb || n_kb !== e_kb) begin errors++; $display("FAIL bad_term kb_data got %h pulses %0d expected %h pulses %0d", kb_data, n_kb, exp_kb, e_kb); end
        checks++; if (n_err !== e_err || err_cnt !== exp_err_cnt()) begin errors++; $display("FAIL bad_term_err pulses got %0d cnt %0d expected %0d cnt %0d", n_err, err_cnt, e_err, exp_err_cnt()); end
    endtask

    task automatic test_len_zero();
        bq_t f;
        f = '{8'hFE, 8'h00, 8'h00, 8'h04, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0A};
        send_frame(f);
        model_frame(f);
        settle();
        checks++; if (kb_data !== 64'h0 || n_kb !== e_kb) begin errors++; $display("FAIL len_zero kb_data got %h pulses %0d expected 0 pulses %0d", kb_data, n_kb, e_kb); end
    endtask

    task automatic test_timeout();
        bq_t f;
        f = '{8'hFE, 8'h08, 8'h00, 8'h04, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(f);
        repeat (41 * DIV) @(posedge clk);
        e_err++; e_errcnt++;
        settle();
        checks++; if (n_err !== e_err || n_kb !== e_kb || kb_data !== exp_kb) begin errors++; $display("FAIL timeout errs got %0d kb %h expected errs %0d kb %h", n_err, kb_data, e_err, exp_kb); end
        f = '{8'hFE, 8'h04, 8'h00, 8'h04, 8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h07, 8'h08, 8'h09, 8'h0A, 8'h0A};
        send_frame(f);
        model_frame(f);
        settle();
        checks++; if (ms_data !== exp_ms || n_ms !== e_ms || n_err !== e_err) begin errors++; $display("FAIL timeout_recover ms_data got %h pulses %0d errs %0d expected %h %0d %0d", ms_data, n_ms, n_err, exp_ms, e_ms, e_err); end
    endtask

    task automatic test_len_error();
        bq_t f;
        f = '{8'hFE, 8'h41, 8'h00, 8'h04, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(f);
        e_err++; e_errcnt++;
        repeat (45 * DIV) @(posedge clk);
        settle();
        checks++; if (n_err !== e_err || err_cnt !== exp_err_cnt() || n_kb !== e_kb) begin errors++; $display("FAIL len_error errs got %0d cnt %0d kb pulses %0d expected %0d %0d %0d", n_err, err_cnt, n_kb, e_err, exp_err_cnt(), e_kb); end
    endtask

    task automatic test_framing();
        bq_t f;
        f = '{8'hFE, 8'h03, 8'h00, 8'h04, 8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
        send_frame(f);
        send_byte(8'h33, 1'b0, 2);
        e_err++; e_errcnt++;
        f = '{8'hFE, 8'h03, 8'h00, 8'h04, 8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h5A, 8'h6B, 8'h7C, 8'h0A};
        send_frame(f);
        model_frame(f);
        settle();
        checks++; if (n_err !== e_err || ms_data !== exp_ms || n_ms !== e_ms) begin errors++; $display("FAIL framing errs got %0d ms %h pulses %0d expected %0d %h %0d", n_err, ms_data, n_ms, e_err, exp_ms, e_ms); end
    endtask

    task automatic test_glitch();
        bq_t f;
        f = '{8'hFE, 8'h02, 8'h00, 8'h04, 8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
              8'hC3, 8'h3C, 8'h0A};
        for (int i = 0; i < 6; i++) send_byte(f[i], 1'b1, 0);
        rxd = 1'b0;
        repeat ((3 * DIV) / 10) @(posedge clk);
        rxd = 1'b1;
        repeat (2 * DIV) @(posedge clk);
        for (int i = 6; i < f.size(); i++) send_byte(f[i], 1'b1, 0);
        model_frame(f);
        settle();
        checks++; if (n_err !== e_err || ms_data !== exp_ms || n_ms !== e_ms) begin errors++; $display("FAIL glitch errs got %0d ms %h pulses %0d expected %0d %h %0d", n_err, ms_data, n_ms, e_err, exp_ms, e_ms); end
    endtask

    task automatic test_random();
        bq_t         f;
        logic [7:0]  dtypes [4];
        int          len;
        dtypes = '{8'h06, 8'h02, 8'h04, 8'h01};
        for (int n = 0; n < 5; n++) begin
            len = $urandom_range(0, 6);
            f = {};
            f.push_back(8'hFE);
            f.push_back(8'(len));
            f.push_back(8'h00);
            f.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h04);
            f.push_back(dtypes[$urandom_range(0, 3)]);
            for (int i = 0; i < 6; i++) f.push_back(8'($urandom));
            for (int i = 0; i < len; i++) f.push_back(8'($urandom));
            f.push_back(($urandom_range(0, 4) == 0) ? 8'h0B : 8'h0A);
            send_frame(f);
            model_frame(f);
            settle();
            checks++; if (kb_data !== exp_kb || ms_data !== exp_ms || gp_data !== exp_gp) begin errors++; $display("FAIL random%0d data got kb=%h ms=%h gp=%h expected kb=%h ms=%h gp=%h", n, kb_data, ms_data, gp_data, exp_kb, exp_ms, exp_gp); end
            checks++; if (n_kb !== e_kb || n_ms !== e_ms || n_gp !== e_gp || n_err !== e_err || err_cnt !== exp_err_cnt()) begin errors++; $display("FAIL random%0d counts got %0d/%0d/%0d err %0d cnt %0d expected %0d/%0d/%0d err %0d cnt %0d", n, n_kb, n_ms, n_gp, n_err, err_cnt, e_kb, e_ms, e_gp, e_err, exp_err_cnt()); end
        end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL pulse_shape got %0d violations expected 0", n_bad); end
    endtask

    task automatic test_reset_mid_frame();
        bq_t f;
        f = '{8'hFE, 8'h08, 8'h00, 8'h04, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h01, 8'h02, 8'h03};
        send_frame(f);
        rxd = 1'b0;
        repeat (DIV / 2) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        checks++; if ({kb_data, ms_data, gp_data, kb_rdy, ms_rdy, gp_rdy, err_pulse, err_cnt} !== '0) begin errors++; $display("FAIL reset_async outputs got kb=%h ms=%h gp=%h err_cnt=%h expected all 0", kb_data, ms_data, gp_data, err_cnt); end
        rxd = 1'b1;
        exp_kb = '0; exp_ms = '0; exp_gp = '0; e_errcnt = 0;
        repeat (5) @(posedge clk);
        reset = 1'b1;
        f = '{8'hFE, 8'h08, 8'h00, 8'h04, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h9C, 8'h00, 8'h2D, 8'h00, 8'h00, 8'h00, 8'h00, 8'hE1, 8'h0A};
        send_frame(f);
        model_frame(f);
        settle();
        checks++; if (kb_data !== exp_kb || n_kb !== e_kb || n_err !== e_err || err_cnt !== exp_err_cnt()) begin errors++; $display("FAIL reset_recover kb %h pulses %0d errs %0d cnt %0d expected %h %0d %0d %0d", kb_data, n_kb, n_err, err_cnt, exp_kb, e_kb, e_err, exp_err_cnt()); end
        checks++; if (ms_data !== 32'h0 || gp_data !== 64'h0) begin errors++; $display("FAIL reset_recover_other ms %h gp %h expected 0 0", ms_data, gp_data); end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_keyboard();
        test_mouse_zero_fill();
        test_bad_term();
        test_gamepad_excess();
        test_len_zero();
        test_timeout();
        test_len_error();
        test_framing();
        test_glitch();
        test_random();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
